// File: rtl/mchan_rr_pkg.sv
// Shared helpers for the mchan round-robin arbiter and response tracker.
//   clog2_min1 : ceil(log2(v)), never below 1 (keeps index/counter widths legal)
//   idx_w/cnt_w: master-index width and outstanding-counter width
//   rr_pick    : circular first-one search starting at a pointer
package mchan_rr_pkg;

  localparam int MAX_MASTERS = 64;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } rr_pick_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int idx_w(input int n_masters);
    return clog2_min1(n_masters);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2_min1(depth + 1);
  endfunction

  // Offsets are walked from farthest to nearest so the last hit, which
  // overwrites the rest, is the first requester at or after ptr.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input int ptr, input int n);
    rr_pick_t p;
    int       k;
    p = '0;
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (i < n) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (req[k]) begin
          p.found = 1'b1;
          p.idx   = 8'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mchan_rr_id_fifo.sv
// In-order FIFO of granted master indices with an occupancy counter.
//   push/push_data : enqueue an index (ignored when full, even if popping)
//   pop            : dequeue the head (ignored when empty)
//   head           : index at the front of the queue
//   full/empty     : occupancy flags (count == DEPTH / count == 0)
// Pointers wrap at DEPTH-1 so any DEPTH >= 1 works.
module mchan_rr_id_fifo
  import mchan_rr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_data,
  input  logic             pop,
  output logic [IDX_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = clog2_min1(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mchan_rr_resp_tracker.sv
// Round-robin arbiter for N masters onto one in-order downstream port, with
// response routing back to the originating master.
//   req_i/req_data_i : per-master request and payload (master k at [k*REQ_W +: REQ_W])
//   gnt_o            : combinational one-hot grant (winner & gnt_i & req_o)
//   req_o/req_data_o : downstream request and winner payload
//   gnt_i            : downstream grant
//   r_valid_i/r_data_i : downstream response (no back-pressure)
//   r_valid_o/r_data_o : routed response valid (one-hot) and broadcast data
//   err_o            : sticky, set by a response arriving with nothing outstanding
module mchan_rr_resp_tracker
  import mchan_rr_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int DEPTH     = 8,
  parameter int REQ_W     = 32,
  parameter int RESP_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTERS-1:0]       req_i,
  input  logic [N_MASTERS*REQ_W-1:0] req_data_i,
  output logic [N_MASTERS-1:0]       gnt_o,
  output logic                       req_o,
  output logic [REQ_W-1:0]           req_data_o,
  input  logic                       gnt_i,
  input  logic                       r_valid_i,
  input  logic [RESP_W-1:0]          r_data_i,
  output logic [N_MASTERS-1:0]       r_valid_o,
  output logic [RESP_W-1:0]          r_data_o,
  output logic                       err_o
);

  localparam int IDX_W = idx_w(N_MASTERS);

  logic [N_MASTERS-1:0][REQ_W-1:0] req_arr;
  logic [IDX_W-1:0]                rr_q, winner, head;
  rr_pick_t                        pick;
  logic                            full, empty, accept, pop;
  logic                            unused_idx;

  assign pick       = rr_pick(MAX_MASTERS'(req_i), int'(rr_q), N_MASTERS);
  assign winner     = pick.idx[IDX_W-1:0];
  assign unused_idx = ^pick.idx;

  assign req_arr    = req_data_i;
  assign req_o      = pick.found & ~full;
  assign req_data_o = req_arr[winner];
  assign accept     = req_o & gnt_i;
  // empty is the pre-push state, so a response never matches a same-cycle accept
  assign pop        = r_valid_i & ~empty;
  assign r_data_o   = r_data_i;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_lane
    assign gnt_o[k]     = accept & (winner == IDX_W'(k));
    assign r_valid_o[k] = pop & (head == IDX_W'(k));
  end

  mchan_rr_id_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      err_o <= 1'b0;
    end else begin
      if (accept) rr_q <= (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
      if (r_valid_i && empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mchan_rr_resp_tracker.sv
// Scoreboard bench: the stimulus process runs a queue-based reference model
// and pushes the expected per-cycle outputs; the monitor pops and compares
// them on the falling edge. A second small instance (3 masters) covers
// non-power-of-2 wrap.
module tb_mchan_rr_resp_tracker;

  localparam int N = 4, D = 8, W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   req_data_i;
  logic [N-1:0]     gnt_o;
  logic             req_o;
  logic [W-1:0]     req_data_o;
  logic             gnt_i;
  logic             r_valid_i;
  logic [W-1:0]     r_data_i;
  logic [N-1:0]     r_valid_o;
  logic [W-1:0]     r_data_o;
  logic             err_o;

  // 3-master instance
  logic             rst3;
  logic [2:0]       req3, gnt3_o, rv3_o;
  logic [3*W-1:0]   req3_data;
  logic             req3_o, gnt3_i, rv3_i, err3_o;
  logic [W-1:0]     req3_data_o, rd3_o;

  always #5 clk = ~clk;

  mchan_rr_resp_tracker #(.N_MASTERS(N), .DEPTH(D), .REQ_W(W), .RESP_W(W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_data_i(req_data_i), .gnt_o(gnt_o),
    .req_o(req_o), .req_data_o(req_data_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
    .r_data_i(r_data_i), .r_valid_o(r_valid_o), .r_data_o(r_data_o), .err_o(err_o));

  mchan_rr_resp_tracker #(.N_MASTERS(3), .DEPTH(2), .REQ_W(W), .RESP_W(W)) dut3 (
    .clk(clk), .rst(rst3), .req_i(req3), .req_data_i(req3_data), .gnt_o(gnt3_o),
    .req_o(req3_o), .req_data_o(req3_data_o), .gnt_i(gnt3_i), .r_valid_i(rv3_i),
    .r_data_i(32'h5A5A), .r_valid_o(rv3_o), .r_data_o(rd3_o), .err_o(err3_o));

  typedef struct {
    logic [N-1:0] gnt;
    logic         req;
    logic         chk_data;
    logic [W-1:0] req_data;
    logic [N-1:0] rv;
    logic [W-1:0] rd;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_chk = 0, n_pass = 0;

  // reference model state
  int   m_out[$];  // outstanding master ids, oldest first
  int   m_rr = 0;
  logic m_err = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("gnt_o", W'(gnt_o), W'(e_mon.gnt));
      check("req_o", W'(req_o), W'(e_mon.req));
      if (e_mon.chk_data) check("req_data_o", req_data_o, e_mon.req_data);
      check("r_valid_o", W'(r_valid_o), W'(e_mon.rv));
      check("r_data_o", r_data_o, e_mon.rd);
      check("err_o", W'(err_o), W'(e_mon.err));
    end
  end

  // One cycle of stimulus plus model step.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic g,
                     input logic rv, input logic [W-1:0] rd);
    exp_t e;
    int   win;
    @(posedge clk); #1;
    rst = r; req_i = rq; gnt_i = g; r_valid_i = rv; r_data_i = rd;
    for (int i = 0; i < N; i++) req_data_i[i*W +: W] = $urandom;
    if (r) begin m_out.delete(); m_rr = 0; m_err = 1'b0; end
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (rq[(m_rr + i) % N]) win = (m_rr + i) % N;
    e.req      = (win >= 0) && (m_out.size() < D);
    e.chk_data = e.req;
    e.req_data = e.req ? req_data_i[win*W +: W] : '0;
    e.gnt      = (e.req && g) ? N'(1 << win) : '0;
    e.rv       = (rv && m_out.size() > 0) ? N'(1 << m_out[0]) : '0;
    e.rd       = rd;
    e.err      = m_err;
    exp_q.push_back(e);
    if (!r) begin
      if (rv && m_out.size() == 0) m_err = 1'b1;
      if (rv && m_out.size() > 0) void'(m_out.pop_front());
      if (e.req && g) begin m_out.push_back(win); m_rr = (win + 1) % N; end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (m_out.size() > 0 && guard < 2*D) begin
      cyc(1'b0, '0, 1'b0, 1'b1, $urandom);
      guard++;
    end
  endtask

  initial begin
    rst = 1'b1; req_i = '0; req_data_i = '0; gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
    rst3 = 1'b1; req3 = '0; req3_data = {32'h3333, 32'h2222, 32'h1111}; gnt3_i = 1'b0; rv3_i = 1'b0;

    // reset with random inputs, then idle
    repeat (3) cyc(1'b1, N'($urandom), $urandom, $urandom, $urandom);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, '0);

    // fairness: 8 grants 0..3,0..3 then full
    repeat (9) cyc(1'b0, 4'b1111, 1'b1, 1'b0, '0);
    // full with simultaneous pop: blocked, then granted next cycle
    cyc(1'b0, 4'b0010, 1'b1, 1'b1, 32'h11);
    cyc(1'b0, 4'b0010, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b0010, 1'b1, 1'b0, '0);
    drain();

    // routing: masters 2, 0, 3 then responses A, B, C
    cyc(1'b0, 4'b0100, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b0001, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b1000, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hA);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hB);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hC);

    // skip and wrap: rr=3 after granting 2, then 0101 grants 0, then 1111 grants 1
    cyc(1'b0, 4'b0100, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b0101, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, '0);
    drain();

    // error after mid-operation reset
    cyc(1'b0, 4'b0011, 1'b1, 1'b0, '0);
    cyc(1'b0, 4'b0011, 1'b1, 1'b0, '0);
    cyc(1'b1, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hDEAD);
    repeat (3) cyc(1'b0, 4'b0001, 1'b1, 1'b0, '0);
    drain();
    cyc(1'b1, '0, 1'b0, 1'b0, '0);

    // randomized traffic with rare resets
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 149) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) < 4), $urandom);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());

    // 3-master instance: rr wraps 2 -> 0, full blocks, routing
    @(posedge clk); #1; rst3 = 1'b0; req3 = 3'b010; gnt3_i = 1'b1;
    #1 check("n3_gnt_first", W'(gnt3_o), W'(3'b010));
    @(posedge clk); #1; req3 = 3'b011;
    #1 check("n3_gnt_wrap", W'(gnt3_o), W'(3'b001));
    @(posedge clk); #1; rv3_i = 1'b1;
    #1 check("n3_gnt_full", W'(gnt3_o), W'(3'b000));
    check("n3_rv_head", W'(rv3_o), W'(3'b010));
    @(posedge clk); #1;
    #1 check("n3_gnt_after", W'(gnt3_o), W'(3'b010));
    check("n3_rv_second", W'(rv3_o), W'(3'b001));
    check("n3_err", W'(err3_o), W'(1'b0));
    @(posedge clk); #1; req3 = '0; gnt3_i = 1'b0; rv3_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
